// File: rtl/lcd_timing_controller.sv
// lcd_timing_controller: dot/line timing, STAT mode and CPU access windows.
// Optional macro LCD_TIMING_STAT_IRQ_EN builds the STAT line and stat_irq.
module lcd_timing_controller #(
   parameter int DOTS_PER_LINE   = 456,
   parameter int VISIBLE_LINES   = 144,
   parameter int LINES_PER_FRAME = 154,
   parameter int OAM_DOTS        = 80,
   parameter int XFER_DOTS       = 172
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_enable,
   input  logic [7:0] lyc,
   input  logic [3:0] stat_int_en,
   output logic       drawline,
   output logic [7:0] ly,
   output logic [1:0] mode,
   output logic       lyc_match,
   output logic       vblank_irq,
   output logic       stat_irq,
   output logic       frame_done,
   output logic       vram_cpu_ok,
   output logic       oam_cpu_ok
);

   localparam int DW = $clog2(DOTS_PER_LINE);
   localparam logic [DW-1:0] DOT_LAST = DW'(DOTS_PER_LINE - 1);
   localparam logic [DW-1:0] DOT_XFER = DW'(OAM_DOTS);
   localparam logic [DW-1:0] DOT_HBL  = DW'(OAM_DOTS + XFER_DOTS);
   localparam logic [7:0] LY_VIS      = 8'(VISIBLE_LINES);
   localparam logic [7:0] LY_LAST_VIS = 8'(VISIBLE_LINES - 1);
   localparam logic [7:0] LY_LAST     = 8'(LINES_PER_FRAME - 1);

   typedef enum logic [2:0] {
      S_OFF, S_OAM, S_XFER, S_HBLANK, S_VBLANK
   } state_t;

   state_t        state, nxt_state;
   logic [DW-1:0] dot, nxt_dot;
   logic [7:0]    nxt_ly;
   logic          nxt_draw, nxt_vbl, nxt_done;

   function automatic logic [1:0] mode_of(state_t s);
      case (s)
         S_OAM:    return 2'd2;
         S_XFER:   return 2'd3;
         S_VBLANK: return 2'd1;
         default:  return 2'd0;
      endcase
   endfunction

   // Next position and state while the display is running
   always_comb begin
      nxt_state = state;
      nxt_dot   = dot;
      nxt_ly    = ly;
      nxt_draw  = 1'b0;
      nxt_vbl   = 1'b0;
      nxt_done  = 1'b0;
      if (dot == DOT_LAST) begin
         nxt_dot = '0;
         if (ly == LY_LAST) begin
            nxt_ly    = 8'd0;
            nxt_state = S_OAM;
            nxt_done  = 1'b1;
         end else if (ly == LY_LAST_VIS) begin
            nxt_ly    = LY_VIS;
            nxt_state = S_VBLANK;
            nxt_vbl   = 1'b1;
         end else begin
            nxt_ly    = ly + 8'd1;
            nxt_state = (ly < LY_LAST_VIS) ? S_OAM : S_VBLANK;
         end
      end else begin
         nxt_dot = dot + 1'b1;
         if (state == S_OAM && nxt_dot == DOT_XFER) begin
            nxt_state = S_XFER;
            nxt_draw  = 1'b1;
         end else if (state == S_XFER && nxt_dot == DOT_HBL) begin
            nxt_state = S_HBLANK;
         end
      end
   end

   // Timing FSM with registered mode, pulses and access windows
   always_ff @(posedge clk) begin
      if (!reset || !lcd_enable) begin
         state       <= S_OFF;
         dot         <= '0;
         ly          <= 8'd0;
         mode        <= 2'd0;
         drawline    <= 1'b0;
         vblank_irq  <= 1'b0;
         frame_done  <= 1'b0;
         vram_cpu_ok <= 1'b1;
         oam_cpu_ok  <= 1'b1;
      end else if (state == S_OFF) begin
         state       <= S_OAM;
         dot         <= '0;
         ly          <= 8'd0;
         mode        <= 2'd2;
         drawline    <= 1'b0;
         vblank_irq  <= 1'b0;
         frame_done  <= 1'b0;
         vram_cpu_ok <= 1'b1;
         oam_cpu_ok  <= 1'b0;
      end else begin
         state       <= nxt_state;
         dot         <= nxt_dot;
         ly          <= nxt_ly;
         mode        <= mode_of(nxt_state);
         drawline    <= nxt_draw;
         vblank_irq  <= nxt_vbl;
         frame_done  <= nxt_done;
         vram_cpu_ok <= (nxt_state != S_XFER);
         oam_cpu_ok  <= (nxt_state != S_XFER) && (nxt_state != S_OAM);
      end
   end

   // Coincidence flag, frozen while the display is off
   always_ff @(posedge clk) begin
      if (!reset)
         lyc_match <= 1'b0;
      else if (lcd_enable && state != S_OFF)
         lyc_match <= (ly == lyc);
   end

`ifdef LCD_TIMING_STAT_IRQ_EN
   logic [1:0] mode_q;
   logic       on_q;
   logic       stat_line;
   logic       stat_prev;

   // Mode sources lag one cycle to line up with the registered lyc_match,
   // so a hand-over between sources at a line boundary leaves no gap.
   assign stat_line = (stat_int_en[3] & lyc_match)
                    | (stat_int_en[2] & (mode_q == 2'd2))
                    | (stat_int_en[1] & (mode_q == 2'd1))
                    | (stat_int_en[0] & (mode_q == 2'd0) & on_q);

   // Rising-edge detector on the STAT line
   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_q    <= 2'd0;
         on_q      <= 1'b0;
         stat_prev <= 1'b0;
         stat_irq  <= 1'b0;
      end else begin
         mode_q    <= mode;
         on_q      <= (state != S_OFF);
         stat_prev <= stat_line;
         stat_irq  <= lcd_enable && (state != S_OFF)
                      && stat_line && !stat_prev;
      end
   end
`else
   logic unused_stat_en;
   assign unused_stat_en = ^stat_int_en;
   assign stat_irq = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_timing_controller.sv
// tb_lcd_timing_controller: random and directed checks against a
// frame-position reference model of the LCD timing.
module tb_lcd_timing_controller;

   localparam int DOTS  = 456;
   localparam int VIS   = 144;
   localparam int LINES = 154;
   localparam int OAMD  = 80;
   localparam int XFERD = 172;
   localparam int FRAME = DOTS * LINES;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] lyc_in = 8'd0;
   logic [3:0] sie = 4'd0;
   logic       drawline, lyc_match, vblank_irq, stat_irq, frame_done;
   logic       vram_cpu_ok, oam_cpu_ok;
   logic [7:0] ly;
   logic [1:0] mode;

   int checks = 0;
   int errors = 0;

   // reference model: position in frame as a single cycle index
   bit       m_act = 0;
   int       m_t = 0;
   bit       m_lm = 0;
   bit       m_lprev = 0;
   bit [1:0] m_mq = 0;
   bit       m_aq = 0;
   bit       e_draw = 0, e_vbl = 0, e_done = 0, e_stat = 0;

   lcd_timing_controller dut (
      .clk(clk),
      .reset(rst_n),
      .lcd_enable(en),
      .lyc(lyc_in),
      .stat_int_en(sie),
      .drawline(drawline),
      .ly(ly),
      .mode(mode),
      .lyc_match(lyc_match),
      .vblank_irq(vblank_irq),
      .stat_irq(stat_irq),
      .frame_done(frame_done),
      .vram_cpu_ok(vram_cpu_ok),
      .oam_cpu_ok(oam_cpu_ok)
   );

   always #5 clk = ~clk;

   function automatic int m_ly();
      return m_act ? m_t / DOTS : 0;
   endfunction

   function automatic int m_mode();
      int l, d;
      l = m_t / DOTS;
      d = m_t % DOTS;
      if (!m_act) return 0;
      if (l >= VIS) return 1;
      if (d < OAMD) return 2;
      if (d < OAMD + XFERD) return 3;
      return 0;
   endfunction

   function automatic void step_model();
      int  ly_o, md_o;
      bit  act_o, st;
      ly_o  = m_ly();
      md_o  = m_mode();
      act_o = m_act;
      st = (sie[3] && m_lm) || (sie[2] && m_mq == 2)
         || (sie[1] && m_mq == 1) || (sie[0] && m_mq == 0 && m_aq);
      e_draw = 0;
      e_vbl  = 0;
      e_done = 0;
      e_stat = 0;
      if (!rst_n) begin
         m_act = 0; m_t = 0; m_lm = 0;
         m_lprev = 0; m_mq = 0; m_aq = 0;
      end else begin
         if (en && act_o) m_lm = (ly_o == int'(lyc_in));
`ifdef LCD_TIMING_STAT_IRQ_EN
         e_stat = en && act_o && st && !m_lprev;
`endif
         m_lprev = st;
         m_mq = 2'(md_o);
         m_aq = act_o;
         if (!en) begin
            m_act = 0; m_t = 0;
         end else if (!act_o) begin
            m_act = 1; m_t = 0;
         end else begin
            m_t = (m_t + 1) % FRAME;
            e_draw = (m_t % DOTS == OAMD) && (m_t / DOTS < VIS);
            e_vbl  = (m_t == VIS * DOTS);
            e_done = (m_t == 0);
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [16:0] got,
                      input logic [16:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (t=%0d)",
                tag, got, exp, m_t);
      end
   endtask

   task automatic check_all();
      int md;
      md = m_mode();
      chk("ly", 17'(ly), 17'(m_ly()));
      chk("mode", 17'(mode), 17'(md));
      chk("drawline", 17'(drawline), 17'(e_draw));
      chk("lyc_match", 17'(lyc_match), 17'(m_lm));
      chk("vblank_irq", 17'(vblank_irq), 17'(e_vbl));
      chk("stat_irq", 17'(stat_irq), 17'(e_stat));
      chk("frame_done", 17'(frame_done), 17'(e_done));
      chk("vram_ok", 17'(vram_cpu_ok), 17'(!(m_act && md == 3)));
      chk("oam_ok", 17'(oam_cpu_ok),
          17'(!(m_act && (md == 2 || md == 3))));
   endtask

   task automatic tick();
      @(posedge clk);
      step_model();
      #1;
      check_all();
   endtask

   initial begin
      int stat_cnt, draws, vbls, vbl_ly, done_k, exp_stat;
`ifdef LCD_TIMING_STAT_IRQ_EN
      exp_stat = 1;
`else
      exp_stat = 0;
`endif
      // reset held with display on request pending
      rst_n = 1'b0; en = 1'b1; lyc_in = 8'd5; sie = 4'b1001;
      repeat (3) tick();
      chk("rst_mode", 17'(mode), 17'd0);
      chk("rst_vram", 17'(vram_cpu_ok), 17'd1);

      // first active cycle: OAM, line 0
      rst_n = 1'b1;
      tick();
      chk("start_mode", 17'(mode), 17'd2);
      chk("start_ly", 17'(ly), 17'd0);
      repeat (OAMD) tick();
      chk("draw_dot80", 17'(drawline), 17'd1);
      chk("xfer_mode", 17'(mode), 17'd3);
      repeat (XFERD) tick();
      chk("hblank_dot252", 17'(mode), 17'd0);

      // HBLANK of line 4 hands over to LYC match of line 5
      stat_cnt = 0;
      for (int i = 0; i < 8 * DOTS + 100 - (OAMD + XFERD); i++) begin
         tick();
         if (stat_irq && m_t >= 4 * DOTS && m_t < 6 * DOTS) stat_cnt++;
      end
      chk("stat_l4_l5", 17'(stat_cnt), 17'(exp_stat));
      chk("pre_drop_mode", 17'(mode), 17'd3);

      // abort the line mid-XFER
      en = 1'b0;
      tick();
      chk("drop_mode", 17'(mode), 17'd0);
      chk("drop_ly", 17'(ly), 17'd0);
      chk("drop_vram", 17'(vram_cpu_ok), 17'd1);
      chk("drop_oam", 17'(oam_cpu_ok), 17'd1);
      chk("drop_draw", 17'(drawline), 17'd0);
      tick();

      // one full frame with LYC=10 as the only STAT source
      lyc_in = 8'd10; sie = 4'b1000; en = 1'b1;
      tick();
      draws = 0; vbls = 0; vbl_ly = -1; done_k = -1; stat_cnt = 0;
      for (int k = 1; k <= FRAME + 2; k++) begin
         tick();
         if (drawline && k <= FRAME) draws++;
         if (vblank_irq) begin vbls++; vbl_ly = int'(ly); end
         if (frame_done && done_k < 0) done_k = k;
         if (stat_irq && k < FRAME) stat_cnt++;
         if (k == 10 * DOTS) chk("lm_pre", 17'(lyc_match), 17'd0);
         if (k == 10 * DOTS + 1) chk("lm_rise", 17'(lyc_match), 17'd1);
         if (k == FRAME) chk("ly_wrap", 17'(ly), 17'd0);
      end
      chk("draw_count", 17'(draws), 17'(VIS));
      chk("vbl_count", 17'(vbls), 17'd1);
      chk("vbl_ly", 17'(vbl_ly), 17'(VIS));
      chk("done_cycle", 17'(done_k), 17'(FRAME));
      chk("stat_frame", 17'(stat_cnt), 17'(exp_stat));

      // random sources, compare values, resets and disables
      for (int it = 0; it < 6; it++) begin
         int n;
         lyc_in = 8'($urandom_range(0, 3));
         sie = 4'($urandom);
         en = 1'b1;
         n = $urandom_range(300, 1500);
         for (int i = 0; i < n; i++) begin
            tick();
            if (i == n / 2) lyc_in = 8'($urandom_range(0, 3));
         end
         if (it % 2 == 1) begin
            rst_n = 1'b0;
            tick();
            chk("rrst_mode", 17'(mode), 17'd0);
            chk("rrst_oam", 17'(oam_cpu_ok), 17'd1);
            repeat ($urandom_range(0, 2)) tick();
            rst_n = 1'b1;
         end else begin
            en = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
         end
      end
      en = 1'b1;
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
